decoder_3to8_seq: RTL and testbench

DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

---
 rtl/decoder_3to8_seq.sv | 176 +++++++++++++++++
 tb/tb_decoder_3to8_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8_seq.sv
// ----------------------------------------------------------------------------
// decoder_3to8_seq
// Registered 3-to-8 one-hot decoder that holds each decoded line for
// PULSE_LEN cycles, follows it with a one-cycle zero gap, and counts the
// codes it has decoded.
//
// Optional feature: define DECODER_SWEEP_EN to add the sweep_start /
// sweep_done ports and a self-sweep that walks codes 0..7 in order.
// The default build (macro undefined) has no sweep logic or ports.
// ----------------------------------------------------------------------------
module decoder_3to8_seq #(
   parameter int PULSE_LEN = 4   // cycles each one-hot value is held, 1..16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [2:0] in_code,
   input  logic       in_en,
   output logic       in_ready,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic [7:0] code_cnt
`ifdef DECODER_SWEEP_EN
   ,
   input  logic       sweep_start,
   output logic       sweep_done
`endif
);

   // Hold counter reload value; the last held cycle is the one where it is 0.
   localparam logic [3:0] HOLD_INIT = 4'(PULSE_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_GAP   = 2'd2,
      ST_SWEEP = 2'd3
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] hold_cnt;

`ifdef DECODER_SWEEP_EN
   logic [2:0] sweep_code;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // values from before the edge; blocking here would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state decision from the current state, inputs and hold counter.
   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
`ifdef DECODER_SWEEP_EN
            if (sweep_start)
               next_state = ST_SWEEP;
            else
`endif
            if (in_valid && in_en)
               next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_cnt == 4'd0) next_state = ST_GAP;
         end
         ST_GAP: begin
            next_state = ST_IDLE;
         end
         ST_SWEEP: begin
`ifdef DECODER_SWEEP_EN
            // Leave once code 7 has been shown and its gap cycle is in progress.
            if (!dout_valid && sweep_code == 3'd7) next_state = ST_IDLE;
`else
            next_state = ST_IDLE;
`endif
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Handshake output: the block only takes a new code while idle.
   always_comb begin
      in_ready = (state == ST_IDLE);
   end

   // Registered decode datapath: one-hot output, hold counter, code counter.
   // NOTE: every register here is cleared by the asynchronous reset so a
   // pulse in flight is aborted immediately rather than finishing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         hold_cnt   <= 4'd0;
         code_cnt   <= 8'h00;
`ifdef DECODER_SWEEP_EN
         sweep_code <= 3'd0;
         sweep_done <= 1'b0;
`endif
      end else begin
`ifdef DECODER_SWEEP_EN
         sweep_done <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
`ifdef DECODER_SWEEP_EN
               if (sweep_start) begin
                  // Sweep wins over a same-cycle offer; start at code 0.
                  sweep_code <= 3'd0;
                  dout       <= 8'h01;
                  dout_valid <= 1'b1;
                  hold_cnt   <= HOLD_INIT;
                  code_cnt   <= code_cnt + 8'd1;
               end else
`endif
               if (in_valid && in_en) begin
                  dout       <= 8'b1 << in_code;
                  dout_valid <= 1'b1;
                  hold_cnt   <= HOLD_INIT;
                  code_cnt   <= code_cnt + 8'd1;
               end
               // An accepted code with in_en low leaves everything as is.
            end
            ST_HOLD: begin
               if (hold_cnt == 4'd0) begin
                  dout       <= 8'h00;
                  dout_valid <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            ST_GAP: begin
               dout       <= 8'h00;
               dout_valid <= 1'b0;
            end
            ST_SWEEP: begin
`ifdef DECODER_SWEEP_EN
               if (dout_valid) begin
                  // Holding the current sweep code, then drop into its gap.
                  if (hold_cnt == 4'd0) begin
                     dout       <= 8'h00;
                     dout_valid <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 4'd1;
                  end
               end else if (sweep_code == 3'd7) begin
                  // Gap after the last code: flag completion, FSM returns idle.
                  sweep_done <= 1'b1;
               end else begin
                  sweep_code <= sweep_code + 3'd1;
                  dout       <= 8'b1 << (sweep_code + 3'd1);
                  dout_valid <= 1'b1;
                  hold_cnt   <= HOLD_INIT;
                  code_cnt   <= code_cnt + 8'd1;
               end
`else
               dout       <= 8'h00;
               dout_valid <= 1'b0;
`endif
            end
            default: begin
               dout       <= 8'h00;
               dout_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// ----------------------------------------------------------------------------
// tb_decoder_3to8_seq
// Self-checking bench for decoder_3to8_seq. Instance a uses PULSE_LEN=4,
// instance b uses PULSE_LEN=1. Expected one-hot values are queued when a
// code is offered and popped when the pulse appears. Inputs are driven and
// outputs sampled on the falling clock edge.
// The sweep scenario is compiled in when DECODER_SWEEP_EN is defined.
// ----------------------------------------------------------------------------
module tb_decoder_3to8_seq;

   localparam int PL_A = 4;
   localparam int PL_B = 1;

   logic       clk;
   logic       rst_n;

   logic       a_in_valid, a_in_en, a_in_ready, a_dout_valid;
   logic [2:0] a_in_code;
   logic [7:0] a_dout, a_code_cnt;

   logic       b_in_valid, b_in_en, b_in_ready, b_dout_valid;
   logic [2:0] b_in_code;
   logic [7:0] b_dout, b_code_cnt;

`ifdef DECODER_SWEEP_EN
   logic       a_sweep_start, a_sweep_done;
   logic       b_sweep_start, b_sweep_done;
`endif

   int         errors = 0;
   int         checks = 0;

   logic [7:0] exp_q_a[$];
   logic [7:0] exp_q_b[$];
   logic [7:0] exp_cnt_a = 8'h00;
   logic [7:0] exp_cnt_b = 8'h00;

   decoder_3to8_seq #(.PULSE_LEN(PL_A)) dut_a (
`ifdef DECODER_SWEEP_EN
      .sweep_start(a_sweep_start),
      .sweep_done (a_sweep_done),
`endif
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_code   (a_in_code),
      .in_en     (a_in_en),
      .in_ready  (a_in_ready),
      .dout      (a_dout),
      .dout_valid(a_dout_valid),
      .code_cnt  (a_code_cnt)
   );

   decoder_3to8_seq #(.PULSE_LEN(PL_B)) dut_b (
`ifdef DECODER_SWEEP_EN
      .sweep_start(b_sweep_start),
      .sweep_done (b_sweep_done),
`endif
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_code   (b_in_code),
      .in_en     (b_in_en),
      .in_ready  (b_in_ready),
      .dout      (b_dout),
      .dout_valid(b_dout_valid),
      .code_cnt  (b_code_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a scenario never returns.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Observe one instance-a pulse starting at the first negedge after the
   // accepting edge; returns at the first negedge where in_ready is high.
   task automatic collect_a(output logic [7:0] val, output int width,
                            output int ready_low, output int bad);
      val = a_dout; width = 0; ready_low = 0; bad = 0;
      for (int n = 0; n < 40; n++) begin
         if ($countones(a_dout) > 1 || a_dout_valid !== (a_dout != 8'h00)) bad++;
         if (a_dout_valid) begin
            width++;
            if (a_dout !== val) bad++;
         end
         if (a_in_ready) return;
         ready_low++;
         @(negedge clk);
      end
      ready_low = -1;
   endtask

   task automatic pop_a(output logic [7:0] v);
      if (exp_q_a.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_a: queue empty, got nothing expected");
         v = 8'hxx;
      end else begin
         v = exp_q_a.pop_front();
      end
   endtask

   task automatic test_reset;
      checks++;
      if (a_dout !== 8'h00 || a_dout_valid !== 1'b0 || a_code_cnt !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: dout=%h valid=%b cnt=%0d, want 00/0/0",
                  a_dout, a_dout_valid, a_code_cnt);
      end
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b, want 1", a_in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1 || a_dout !== 8'h00) begin
         errors++;
         $display("FAIL after_reset: in_ready=%b dout=%h, want 1/00", a_in_ready, a_dout);
      end
   endtask

   task automatic test_single;
      logic [7:0] v, e;
      int w, rl, bad;
      a_in_valid = 1'b1; a_in_code = 3'd3; a_in_en = 1'b1;
      exp_q_a.push_back(8'h08); exp_cnt_a++;
      @(negedge clk);
      a_in_valid = 1'b0;
      collect_a(v, w, rl, bad);
      pop_a(e);
      checks++;
      if (v !== e) begin errors++; $display("FAIL single_value: dout=%h, want %h", v, e); end
      checks++;
      if (w != PL_A) begin errors++; $display("FAIL single_width: %0d cycles, want %0d", w, PL_A); end
      checks++;
      if (rl != PL_A + 1) begin errors++; $display("FAIL single_ready_low: %0d cycles, want %0d", rl, PL_A + 1); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL single_onehot: %0d bad cycles, want 0", bad); end
      checks++;
      if (a_code_cnt !== exp_cnt_a) begin errors++; $display("FAIL single_cnt: %0d, want %0d", a_code_cnt, exp_cnt_a); end
   endtask

   task automatic test_en_zero;
      a_in_valid = 1'b1; a_in_code = 3'd5; a_in_en = 1'b0;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_en = 1'b1;
      checks++;
      if (a_dout !== 8'h00 || a_dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL en0_output: dout=%h valid=%b, want 00/0", a_dout, a_dout_valid);
      end
      checks++;
      if (a_in_ready !== 1'b1 || a_code_cnt !== exp_cnt_a) begin
         errors++;
         $display("FAIL en0_state: ready=%b cnt=%0d, want 1/%0d", a_in_ready, a_code_cnt, exp_cnt_a);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] v, e;
      int w, rl, bad;
      a_in_valid = 1'b1; a_in_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_in_code = 3'(i);
         exp_q_a.push_back(8'h01 << i); exp_cnt_a++;
         @(negedge clk);
         collect_a(v, w, rl, bad);
         pop_a(e);
         checks++;
         if (v !== e || w != PL_A || bad != 0) begin
            errors++;
            $display("FAIL b2b_code%0d: dout=%h width=%0d bad=%0d, want %h/%0d/0", i, v, w, bad, e, PL_A);
         end
      end
      a_in_valid = 1'b0;
      checks++;
      if (a_code_cnt !== exp_cnt_a) begin errors++; $display("FAIL b2b_cnt: %0d, want %0d", a_code_cnt, exp_cnt_a); end
   endtask

   task automatic test_ignore_busy;
      logic [7:0] e;
      int seen = 0;
      a_in_valid = 1'b1; a_in_code = 3'd2; a_in_en = 1'b1;
      exp_q_a.push_back(8'h04); exp_cnt_a++;
      @(negedge clk);
      pop_a(e);
      checks++;
      if (a_dout !== e) begin errors++; $display("FAIL busy_first: dout=%h, want %h", a_dout, e); end
      a_in_code = 3'd6;  // offered while busy, must be dropped
      repeat (PL_A - 1) @(negedge clk);
      a_in_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (a_dout == 8'h40) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL busy_ignored: code6 seen %0d cycles, want 0", seen); end
      checks++;
      if (a_code_cnt !== exp_cnt_a) begin errors++; $display("FAIL busy_cnt: %0d, want %0d", a_code_cnt, exp_cnt_a); end
   endtask

   task automatic test_reset_mid_pulse;
      a_in_valid = 1'b1; a_in_code = 3'd6; a_in_en = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (a_dout !== 8'h40) begin errors++; $display("FAIL midrst_pulse: dout=%h, want 40", a_dout); end
      #2 rst_n = 1'b0;
      #1;
      exp_cnt_a = 8'h00; exp_cnt_b = 8'h00;
      exp_q_a.delete(); exp_q_b.delete();
      checks++;
      if (a_dout !== 8'h00 || a_dout_valid !== 1'b0 || a_code_cnt !== 8'h00) begin
         errors++;
         $display("FAIL midrst_outputs: dout=%h valid=%b cnt=%0d, want 00/0/0", a_dout, a_dout_valid, a_code_cnt);
      end
      checks++;
      if (a_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: %b, want 1", a_in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_wrap_pulse1;
      logic [7:0] e;
      b_in_en = 1'b1; b_in_code = 3'd7;
      for (int i = 0; i < 256; i++) begin
         b_in_valid = 1'b1;
         exp_q_b.push_back(8'h80); exp_cnt_b++;
         @(negedge clk);
         b_in_valid = 1'b0;
         e = exp_q_b.pop_front();
         checks++;
         if (b_dout !== e || b_dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse%0d: dout=%h valid=%b, want %h/1", i, b_dout, b_dout_valid, e);
         end
         @(negedge clk);
         checks++;
         if (b_dout !== 8'h00 || b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_gap%0d: dout=%h ready=%b, want 00/0", i, b_dout, b_in_ready);
         end
         @(negedge clk);
         if (i == 254) begin
            checks++;
            if (b_code_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: cnt=%0d, want 255", b_code_cnt); end
         end
      end
      checks++;
      if (b_code_cnt !== exp_cnt_b || b_code_cnt !== 8'd0) begin
         errors++;
         $display("FAIL wrap_zero: cnt=%0d, want 0", b_code_cnt);
      end
   endtask

`ifdef DECODER_SWEEP_EN
   task automatic test_sweep;
      logic [7:0] cur, want;
      int done_idx = -1;
      int done_cnt = 0;
      int bad = 0;
      a_sweep_start = 1'b1;
      a_in_valid = 1'b1; a_in_code = 3'd2; a_in_en = 1'b1;  // loses to sweep
      for (int k = 0; k < 8; k++) exp_q_a.push_back(8'h01 << k);
      exp_cnt_a = exp_cnt_a + 8'd8;
      @(negedge clk);
      a_sweep_start = 1'b0; a_in_valid = 1'b0;
      cur = 8'h00;
      for (int n = 0; n < 50; n++) begin
         if (n < 40) begin
            if (n % 5 == 0) pop_a(cur);
            want = (n % 5 < PL_A) ? cur : 8'h00;
            if (a_dout !== want || a_in_ready !== 1'b0) bad++;
         end
         if (a_sweep_done) begin done_cnt++; done_idx = n; end
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL sweep_sequence: %0d bad cycles, want 0", bad); end
      checks++;
      if (done_cnt != 1 || done_idx != 40) begin
         errors++;
         $display("FAIL sweep_done: pulses=%0d at=%0d, want 1 at 40", done_cnt, done_idx);
      end
      checks++;
      if (a_code_cnt !== exp_cnt_a) begin errors++; $display("FAIL sweep_cnt: %0d, want %0d", a_code_cnt, exp_cnt_a); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_code = 3'd0; a_in_en = 1'b0;
      b_in_valid = 1'b0; b_in_code = 3'd0; b_in_en = 1'b0;
`ifdef DECODER_SWEEP_EN
      a_sweep_start = 1'b0; b_sweep_start = 1'b0;
`endif
      repeat (2) @(negedge clk);
      test_reset;
      test_single;
      test_en_zero;
      test_back_to_back;
      test_ignore_busy;
`ifdef DECODER_SWEEP_EN
      test_sweep;
`endif
      test_reset_mid_pulse;
      test_wrap_pulse1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
